// File: rtl/matrix_pkg.sv
// matrix_pkg: constants and state encoding shared by the matrix frame sender
package matrix_pkg;
    localparam int         MAX_ELEMENT_SIZE = 8;
    localparam logic [7:0] PREAMBLE_BYTE    = 8'h55;
    localparam logic [7:0] SFD_BYTE         = 8'hD5;
    localparam int         PREAMBLE_LEN     = 7;
    localparam int         IFG_DIBITS       = 48;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, GAP} state_t;
endpackage

// File: rtl/byte_to_dibit.sv
// byte_to_dibit: byte shift register emitting one dibit per clock, LSB dibit first
module byte_to_dibit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic [1:0] o_dibit
);
    logic [7:0] r_sh;
    // zero fill drains the register to 2'b00 once a byte is spent, so idle output is clean
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_sh <= '0;
        else          r_sh <= i_load ? i_byte : {2'b00, r_sh[7:2]};
    assign o_dibit = r_sh[1:0];
endmodule

// File: rtl/matrix_sender.sv
// matrix_sender: frames result rows as preamble + SFD + payload dibits, then an inter-frame gap
module matrix_sender #(
    parameter int MAX_ELEMENT_SIZE = 8,
    parameter int MAX_COL_SIZE_C   = 32
) (
    input  logic                                       eth_refclk,
    input  logic                                       rst_n,
    input  logic                                       row_valid,
    input  logic [MAX_COL_SIZE_C*MAX_ELEMENT_SIZE-1:0] row_data,
    input  logic                                       row_last,
    input  logic [$clog2(MAX_COL_SIZE_C+1)-1:0]        num_cols,
    output logic                                       row_ready,
    output logic                                       axiov,
    output logic [1:0]                                 axiod,
    output logic                                       busy,
    output logic                                       frame_done,
    output logic                                       underrun
);
    import matrix_pkg::*;
    localparam int RW = MAX_COL_SIZE_C*MAX_ELEMENT_SIZE;
    localparam int NW = $clog2(MAX_COL_SIZE_C+1);
    state_t          r_state;
    logic [1:0]      r_dcnt;
    logic [NW-1:0]   r_bcnt, r_ncols, r_buf_ncols, w_cols;
    logic [5:0]      r_gcnt;
    logic [RW-1:0]   r_row, r_buf_data;
    logic            r_last, r_buf_last, r_buf_full;
    logic            r_axiov, r_frame_done, r_underrun;
    logic            w_byte_end, w_row_end, w_start, w_next_row, w_pop, w_load;
    logic [7:0]      w_byte;
    always_comb begin
        w_cols     = r_buf_ncols == '0 ? NW'(MAX_COL_SIZE_C) : r_buf_ncols;
        w_byte_end = r_dcnt == 2'd3;
        w_row_end  = r_state == PAYLOAD && w_byte_end && r_bcnt == r_ncols - NW'(1);
        w_start    = r_buf_full && (r_state == IDLE || (r_state == GAP && r_gcnt == 6'(IFG_DIBITS - 1)));
        w_next_row = w_row_end && !r_last && r_buf_full;
        w_pop      = w_start || w_next_row;
        w_load     = w_start || (w_byte_end && (r_state == PREAMBLE || r_state == SFD ||
                     (r_state == PAYLOAD && (!w_row_end || w_next_row))));
        w_byte     = (w_start || (r_state == PREAMBLE && r_bcnt != NW'(PREAMBLE_LEN - 1))) ? PREAMBLE_BYTE :
                     r_state == PREAMBLE ? SFD_BYTE :
                     w_next_row ? r_buf_data[7:0] : r_row[7:0];
    end
    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dcnt       <= '0;
            r_bcnt       <= '0;
            r_ncols      <= '0;
            r_gcnt       <= '0;
            r_row        <= '0;
            r_last       <= 1'b0;
            r_buf_data   <= '0;
            r_buf_last   <= 1'b0;
            r_buf_ncols  <= '0;
            r_buf_full   <= 1'b0;
            r_axiov      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_dcnt       <= w_load ? 2'd0 : r_dcnt + 2'd1;
            if (row_valid && !r_buf_full) begin
                r_buf_full  <= 1'b1;
                r_buf_data  <= row_data;
                r_buf_last  <= row_last;
                r_buf_ncols <= num_cols;
            end else if (w_pop) begin
                r_buf_full <= 1'b0;
            end
            // a frame may start from IDLE or straight from the final gap cycle
            if (w_start) begin
                r_state <= PREAMBLE;
                r_axiov <= 1'b1;
                r_bcnt  <= '0;
                r_row   <= r_buf_data;
                r_last  <= r_buf_last;
                r_ncols <= w_cols;
            end else begin
                case (r_state)
                    PREAMBLE: if (w_byte_end) begin
                        r_state <= r_bcnt == NW'(PREAMBLE_LEN - 1) ? SFD : PREAMBLE;
                        r_bcnt  <= r_bcnt + NW'(1);
                    end
                    SFD: if (w_byte_end) begin
                        r_state <= PAYLOAD;
                        r_bcnt  <= '0;
                        r_row   <= r_row >> 8;
                    end
                    PAYLOAD: if (w_next_row) begin
                        r_row  <= r_buf_data >> 8;
                        r_last <= r_buf_last;
                        r_bcnt <= '0;
                    end else if (w_row_end) begin
                        r_state      <= GAP;
                        r_axiov      <= 1'b0;
                        r_gcnt       <= '0;
                        r_frame_done <= r_last;
                        r_underrun   <= !r_last;
                    end else if (w_byte_end) begin
                        r_row  <= r_row >> 8;
                        r_bcnt <= r_bcnt + NW'(1);
                    end
                    GAP: begin
                        r_gcnt  <= r_gcnt + 6'd1;
                        r_state <= r_gcnt == 6'(IFG_DIBITS - 1) ? IDLE : GAP;
                    end
                    default: ;
                endcase
            end
        end
    end
    byte_to_dibit u_b2d (
        .i_clk   (eth_refclk),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .i_byte  (w_byte),
        .o_dibit (axiod)
    );
    assign row_ready  = !r_buf_full;
    assign axiov      = r_axiov;
    assign busy       = r_state != IDLE;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;
endmodule

// File: tb/tb_matrix_sender.sv
// tb_matrix_sender: random rows against a byte-level frame model with gap/underrun/reset scenarios
module tb_matrix_sender;
    logic         eth_refclk = 1'b0;
    logic         rst_n, row_valid, row_last, row_ready, axiov, busy, frame_done, underrun;
    logic [255:0] row_data;
    logic [5:0]   num_cols;
    logic [1:0]   axiod;
    typedef struct {int first; int last; int ndib; int boff; bit done; bit und;} frm_t;
    frm_t         frm[$];
    frm_t         cur;
    logic [7:0]   rx_b[$];
    logic [7:0]   exp_b[$];
    logic [7:0]   sh;
    bit           in_fr = 0;
    int           cyc = 0, idle_bad = 0, n_done = 0, n_und = 0;
    int           n_chk = 0, n_pass = 0;
    matrix_sender dut (
        .eth_refclk (eth_refclk),
        .rst_n      (rst_n),
        .row_valid  (row_valid),
        .row_data   (row_data),
        .row_last   (row_last),
        .num_cols   (num_cols),
        .row_ready  (row_ready),
        .axiov      (axiov),
        .axiod      (axiod),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );
    always #5 eth_refclk = ~eth_refclk;
    always @(posedge eth_refclk) cyc++;
    // collects every axiov=1 run as a frame and reassembles its bytes LSB-dibit first
    always @(negedge eth_refclk) begin
        if (axiov) begin
            if (!in_fr) begin
                in_fr = 1; cur.first = cyc; cur.ndib = 0; cur.boff = rx_b.size();
            end
            sh = {axiod, sh[7:2]};
            cur.ndib++;
            cur.last = cyc;
            if (cur.ndib % 4 == 0) rx_b.push_back(sh);
        end else begin
            if (axiod !== 2'b00) idle_bad++;
            if (in_fr) begin
                in_fr = 0; cur.done = frame_done; cur.und = underrun; frm.push_back(cur);
            end
        end
        if (frame_done) n_done++;
        if (underrun) n_und++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [255:0] rand_row();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction
    task automatic add_pre();
        exp_b.delete();
        repeat (7) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
    endtask
    task automatic add_row(input logic [255:0] d, input int n);
        for (int k = 0; k < n; k++) exp_b.push_back(d[8*k +: 8]);
    endtask
    task automatic send_row(input logic [255:0] d, input bit last, input logic [5:0] nc, input bit hold);
        int t = 0;
        @(negedge eth_refclk);
        row_valid = 1; row_data = d; row_last = last; num_cols = nc;
        while (!row_ready && t < 3000) begin @(negedge eth_refclk); t++; end
        if (t == 3000) chk("accept_timeout", row_ready, 1);
        @(posedge eth_refclk);
        if (!hold) begin @(negedge eth_refclk); row_valid = 0; end
    endtask
    task automatic wait_frames(input int n);
        int t = 0;
        while (frm.size() < n && t < 3000) begin @(negedge eth_refclk); t++; end
        if (frm.size() < n) chk("frame_timeout", frm.size(), n);
    endtask
    task automatic chk_frame(input string tag, input int fi, input bit edone, input bit eund);
        if (fi >= frm.size()) begin chk({tag, "_missing"}, frm.size(), fi + 1); return; end
        chk({tag, "_len"}, frm[fi].ndib, exp_b.size() * 4);
        for (int i = 0; i < exp_b.size() && i < frm[fi].ndib / 4; i++)
            chk($sformatf("%s_b%0d", tag, i), rx_b[frm[fi].boff + i], exp_b[i]);
        chk({tag, "_done"}, frm[fi].done, edone);
        chk({tag, "_und"}, frm[fi].und, eund);
    endtask
    initial begin
        logic [255:0] r0, r1, r2;
        int fi, nd, nu, nr, nc, d, t;
        rst_n = 0; row_valid = 0; row_data = '0; row_last = 0; num_cols = '0;
        repeat (3) @(negedge eth_refclk);
        chk("rst_axiov", axiov, 0);
        chk("rst_axiod", axiod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_und", underrun, 0);
        chk("rst_ready", row_ready, 1);
        rst_n = 1;
        // single row, two elements
        fi = frm.size(); nd = n_done;
        r0 = rand_row(); r0[15:0] = 16'h3CA5;
        add_pre(); add_row(r0, 2);
        send_row(r0, 1, 6'd2, 0);
        wait_frames(fi + 1);
        chk_frame("one", fi, 1, 0);
        if (fi < frm.size()) begin
            t = 0;
            while (cyc < frm[fi].last + 48 && t < 200) begin @(negedge eth_refclk); t++; end
            chk("gap_busy_end", busy, 1);
            @(negedge eth_refclk);
            chk("gap_idle", busy, 0);
        end
        chk("one_no_new", frm.size(), fi + 1);
        chk("one_done_cnt", n_done - nd, 1);
        // back-to-back rows; later num_cols values must be ignored
        fi = frm.size(); nd = n_done;
        r0 = rand_row(); r1 = rand_row(); r2 = rand_row();
        add_pre(); add_row(r0, 4); add_row(r1, 4); add_row(r2, 4);
        send_row(r0, 0, 6'd4, 1);
        send_row(r1, 0, 6'($urandom_range(0, 32)), 1);
        send_row(r2, 1, 6'($urandom_range(0, 32)), 0);
        wait_frames(fi + 1);
        chk_frame("b2b", fi, 1, 0);
        chk("b2b_done_cnt", n_done - nd, 1);
        // underrun: second row arrives late and becomes its own frame
        fi = frm.size(); nu = n_und;
        nc = $urandom_range(1, 8);
        r0 = rand_row(); r1 = rand_row();
        add_pre(); add_row(r0, nc);
        send_row(r0, 0, 6'(nc), 0);
        wait_frames(fi + 1);
        chk_frame("und_a", fi, 0, 1);
        chk("und_cnt", n_und - nu, 1);
        repeat (9) @(negedge eth_refclk);
        nr = $urandom_range(1, 8);
        add_pre(); add_row(r1, nr);
        send_row(r1, 1, 6'(nr), 0);
        wait_frames(fi + 2);
        chk_frame("und_b", fi + 1, 1, 0);
        if (fi + 1 < frm.size()) chk("und_gap", frm[fi + 1].first - frm[fi].last, 49);
        // row presented during the gap
        fi = frm.size();
        r0 = rand_row(); r1 = rand_row();
        add_pre(); add_row(r0, 3);
        send_row(r0, 1, 6'd3, 0);
        wait_frames(fi + 1);
        @(negedge eth_refclk);
        chk("gap_ready", row_ready, 1);
        add_pre(); add_row(r1, 5);
        send_row(r1, 1, 6'd5, 0);
        wait_frames(fi + 2);
        chk_frame("gap_b", fi + 1, 1, 0);
        if (fi + 1 < frm.size()) chk("gap_49", frm[fi + 1].first - frm[fi].last, 49);
        // full width rows
        fi = frm.size();
        r0 = rand_row(); r1 = rand_row();
        add_pre(); add_row(r0, 32); add_row(r1, 32);
        send_row(r0, 0, 6'd0, 1);
        send_row(r1, 1, 6'($urandom_range(1, 32)), 0);
        wait_frames(fi + 1);
        chk_frame("full", fi, 1, 0);
        // random frames, next frame offered at a random point in or after the gap
        for (int n = 0; n < 6; n++) begin
            fi = frm.size();
            nr = $urandom_range(1, 3);
            nc = $urandom_range(0, 32);
            d  = $urandom_range(0, 60);
            repeat (d) @(negedge eth_refclk);
            add_pre();
            for (int r = 0; r < nr; r++) begin
                r0 = rand_row();
                add_row(r0, nc == 0 ? 32 : nc);
                send_row(r0, r == nr - 1, r == 0 ? 6'(nc) : 6'($urandom_range(0, 32)), r != nr - 1);
            end
            wait_frames(fi + 1);
            chk_frame($sformatf("rnd%0d", n), fi, 1, 0);
            if (fi > 0 && fi < frm.size()) begin
                if (d <= 40) chk("rnd_gap_eq", frm[fi].first - frm[fi - 1].last, 49);
                else chk("rnd_gap_min", frm[fi].first - frm[fi - 1].last >= 49, 1);
            end
        end
        // reset in the middle of the payload
        fi = frm.size(); nd = n_done; nu = n_und;
        send_row(rand_row(), 1, 6'd8, 0);
        t = 0;
        while (!axiov && t < 300) begin @(negedge eth_refclk); t++; end
        chk("mid_started", axiov, 1);
        repeat (36) @(negedge eth_refclk);
        chk("mid_in_frame", axiov, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_axiov", axiov, 0);
        chk("mid_axiod", axiod, 0);
        chk("mid_ready", row_ready, 1);
        chk("mid_busy", busy, 0);
        repeat (3) @(negedge eth_refclk);
        rst_n = 1;
        repeat (100) @(negedge eth_refclk);
        chk("mid_frames", frm.size(), fi + 1);
        if (fi < frm.size()) begin
            chk("mid_trunc", frm[fi].ndib < 64, 1);
            chk("mid_rec_done", frm[fi].done, 0);
            chk("mid_rec_und", frm[fi].und, 0);
        end
        chk("mid_no_done", n_done - nd, 0);
        chk("mid_no_und", n_und - nu, 0);
        chk("idle_axiod_zero", idle_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_sender.md
MATRIX_SENDER -- requirements
Module: matrix_sender

Interface
REQ-001 The module SHALL have parameter MAX_ELEMENT_SIZE, default 8, giving the element width in bits; only the value 8 (one byte per element) is supported.
REQ-002 The module SHALL have parameter MAX_COL_SIZE_C, default 32, giving the maximum number of elements per result row.
REQ-003 The module SHALL have port eth_refclk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port row_valid, input, 1 bit: row_data, row_last and num_cols are valid.
REQ-006 The module SHALL have port row_data, input, MAX_COL_SIZE_C*MAX_ELEMENT_SIZE bits: one result row, with element k at bits [8k+7:8k].
REQ-007 The module SHALL have port row_last, input, 1 bit: the row is the final row of the matrix.
REQ-008 The module SHALL have port num_cols, input, $clog2(MAX_COL_SIZE_C+1) bits: the number of elements per row.
REQ-009 The module SHALL have port row_ready, output, 1 bit: the one-row input buffer is empty.
REQ-010 The module SHALL have port axiov, output, 1 bit: the transmit dibit is valid.
REQ-011 The module SHALL have port axiod, output, 2 bits: the transmit dibit.
REQ-012 The module SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-013 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the last payload dibit of a completed frame.
REQ-014 The module SHALL have port underrun, output, 1 bit: a one-cycle pulse when a frame is aborted.

Function
REQ-015 A row SHALL transfer on a cycle where row_valid and row_ready are both high, and SHALL be captured into the one-row buffer together with row_last.
REQ-016 row_ready SHALL equal "buffer empty", independent of state; a buffer entry SHALL be freed on the cycle it loads the shift register.
REQ-017 num_cols SHALL be latched only from the first row of each frame; the value 0 SHALL be treated as MAX_COL_SIZE_C.
REQ-018 The state machine SHALL have the states IDLE, PREAMBLE, SFD, PAYLOAD and GAP.
REQ-019 In IDLE, when the buffer holds a row, the next cycle SHALL be PREAMBLE with axiov=1.
REQ-020 PREAMBLE SHALL drive 28 dibits of 2'b01, which is 7 bytes of 0x55.
REQ-021 SFD SHALL drive the 4 dibits 01,01,01,11, which is 0xD5.
REQ-022 Every byte, including elements, SHALL be sent LSB-dibit first, one dibit per cycle, with no idle cycles inside a frame.
REQ-023 PAYLOAD SHALL send the elements of each row in the order element 0 to element num_cols-1, taking num_cols*4 cycles per row.
REQ-024 When the last dibit of a row is sent and the row is not last, a buffered row SHALL load into the shift register in that same cycle so that the output is continuous.
REQ-025 If the buffer is empty at that point (underrun), axiov SHALL drop on the next cycle, underrun SHALL pulse, and the state SHALL go to GAP.
REQ-026 After the last dibit of a row_last row, frame_done SHALL pulse in the next cycle and the state SHALL go to GAP.
REQ-027 GAP SHALL hold axiov=0 for exactly 48 cycles, then go to IDLE.
REQ-028 Rows SHALL still be accepted into the buffer during GAP, but no frame SHALL start before GAP ends.
REQ-029 When axiov=0, axiod SHALL be 2'b00.
REQ-030 No FCS SHALL be generated; a downstream block appends it.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE and the buffer empty.
REQ-032 While rst_n=0, the outputs SHALL be axiov=0, axiod=0, busy=0, frame_done=0, underrun=0 and row_ready=1.
REQ-033 An assertion of rst_n mid-frame SHALL truncate the frame immediately, with no frame_done and no underrun pulse.
REQ-034 rst_n SHALL be released synchronously to eth_refclk by the top level.

Structure
REQ-035 The shared package matrix_pkg SHALL hold MAX_ELEMENT_SIZE, PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5), PREAMBLE_LEN (7), IFG_DIBITS (48) and the state enum.
REQ-036 The sub-module byte_to_dibit SHALL hold the per-byte dibit shifter; the row shift register, the counters and the FSM SHALL live in matrix_sender.

Verification
REQ-037 The bench SHALL cover this frame: one row, num_cols=2, elements 0xA5, 0x3C, row_last=1 -> 28x01, then 01,01,01,11, then 01,01,10,10, then 00,11,11,00; 40 cycles with axiov=1, then frame_done pulse, then 48 cycles with axiov=0.
REQ-038 The bench SHALL cover this back-to-back case: 3 rows, num_cols=4, row_valid held high -> 32+48 contiguous axiov=1 cycles and one frame_done.
REQ-039 The bench SHALL cover this underrun case: row 0 sent, row 1 presented 10 cycles after the end of row 0 -> axiov falls after row 0, underrun pulses, and row 1 starts a new frame after the gap.
REQ-040 The bench SHALL cover this mid-payload reset: rst_n=0 during PAYLOAD -> axiov=0 asynchronously, row_ready=1, no frame_done.
REQ-041 The bench SHALL cover this gap case: next row presented during GAP -> accepted at once, and the first preamble dibit appears exactly 49 cycles after the last payload dibit.
REQ-042 The bench SHALL cover this full-width case: num_cols=0 -> 32 elements (128 payload dibits) per row.
